// File: rtl/modular_inverter.sv
`default_nettype none
// ============================================================================
// Module   : modular_inverter
// Purpose  : Sequential modular inverse a^-1 mod P using binary extended
//            Euclid. One reduction step per clock.
// Revision : 1.0
// ============================================================================
module modular_inverter #(
  parameter int               WIDTH      = 256,
  parameter logic [WIDTH-1:0] P          = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F,
  parameter int               MAX_CYCLES = 4*WIDTH+4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] inverse,
  output logic             Done,
  output logic             Busy,
  output logic             Error
);

  localparam int               c_cnt_w   = $clog2(MAX_CYCLES+1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(MAX_CYCLES);
  localparam logic [WIDTH:0]   c_p_ext   = {1'b0, P};
  localparam logic [WIDTH-1:0] c_one     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   c_one_ext = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state, w_state_next;
  logic [WIDTH-1:0]   r_a, r_u, r_v, r_inverse;
  logic [WIDTH-1:0]   w_a_next, w_u_next, w_v_next, w_inverse_next;
  logic [WIDTH:0]     r_x1, r_x2, w_x1_next, w_x2_next;
  logic [c_cnt_w-1:0] r_cnt, w_cnt_next;
  logic               r_done, r_error, w_done_next, w_error_next;

  // x/2 mod P: an odd residue is lifted by P first, so one extra bit is needed
  function automatic logic [WIDTH:0] half_mod(input logic [WIDTH:0] x);
    logic [WIDTH:0] s;
    s = x[0] ? (x + c_p_ext) : x;
    return s >> 1;
  endfunction

  function automatic logic [WIDTH:0] sub_mod(input logic [WIDTH:0] x, input logic [WIDTH:0] y);
    return (x >= y) ? (x - y) : (x + c_p_ext - y);
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_u       <= '0;
      r_v       <= '0;
      r_x1      <= '0;
      r_x2      <= '0;
      r_cnt     <= '0;
      r_inverse <= '0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_a       <= w_a_next;
      r_u       <= w_u_next;
      r_v       <= w_v_next;
      r_x1      <= w_x1_next;
      r_x2      <= w_x2_next;
      r_cnt     <= w_cnt_next;
      r_inverse <= w_inverse_next;
      r_done    <= w_done_next;
      r_error   <= w_error_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_a_next       = r_a;
    w_u_next       = r_u;
    w_v_next       = r_v;
    w_x1_next      = r_x1;
    w_x2_next      = r_x2;
    w_cnt_next     = r_cnt;
    w_inverse_next = r_inverse;
    w_done_next    = r_done;
    w_error_next   = r_error;

    unique case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_a_next       = a;
          w_u_next       = a;
          w_v_next       = P;
          w_x1_next      = c_one_ext;
          w_x2_next      = '0;
          w_cnt_next     = '0;
          w_inverse_next = '0;
          w_done_next    = 1'b0;
          w_error_next   = 1'b0;
          w_state_next   = S_CHECK;
        end
      end

      S_CHECK: begin
        if ((r_a == '0) || (r_a >= P)) begin
          w_error_next   = 1'b1;
          w_inverse_next = '0;
          w_done_next    = 1'b1;
          w_state_next   = S_DONE;
        end else begin
          w_state_next   = S_RUN;
        end
      end

      S_RUN: begin
        if (r_u == c_one) begin
          w_inverse_next = r_x1[WIDTH-1:0];
          w_done_next    = 1'b1;
          w_state_next   = S_DONE;
        end else if (r_v == c_one) begin
          w_inverse_next = r_x2[WIDTH-1:0];
          w_done_next    = 1'b1;
          w_state_next   = S_DONE;
        end else if (r_cnt == c_cnt_max) begin
          w_error_next   = 1'b1;
          w_inverse_next = '0;
          w_done_next    = 1'b1;
          w_state_next   = S_DONE;
        end else begin
          w_cnt_next = r_cnt + c_cnt_w'(1);
          if (!r_u[0]) begin
            w_u_next  = r_u >> 1;
            w_x1_next = half_mod(r_x1);
          end else if (!r_v[0]) begin
            w_v_next  = r_v >> 1;
            w_x2_next = half_mod(r_x2);
          end else if (r_u >= r_v) begin
            w_u_next  = r_u - r_v;
            w_x1_next = sub_mod(r_x1, r_x2);
          end else begin
            w_v_next  = r_v - r_u;
            w_x2_next = sub_mod(r_x2, r_x1);
          end
        end
      end

      S_DONE: begin
        // A restart needs Start to fall first, so a held Start cannot retrigger
        if (!Start) w_state_next = S_IDLE;
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  assign inverse = r_inverse;
  assign Done    = r_done;
  assign Error   = r_error;
  assign Busy    = (r_state == S_CHECK) || (r_state == S_RUN);

endmodule
`default_nettype wire
